// File: rtl/gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller: binary and Gray read/write pointers,
// RAM addresses, full/empty/level and sticky overflow/underflow flags.
module gray_ptr_ctrl #(
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  output logic            push_ack,
  output logic            pop_ack,
  output logic [ADDR-1:0] waddr,
  output logic [ADDR-1:0] raddr,
  output logic [ADDR:0]   wgray,
  output logic [ADDR:0]   rgray,
  output logic            full,
  output logic            empty,
  output logic [ADDR:0]   level,
  output logic            ovf,
  output logic            udf
);

  // Gray pointers differ exactly in the top two bits when the FIFO is full.
  localparam logic [ADDR:0] FULL_XOR = (ADDR+1)'(3) << (ADDR-1);

  function automatic logic [ADDR:0] bin_gray(input logic [ADDR:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR:0] wbin_q, wbin_d;
  logic [ADDR:0] rbin_q, rbin_d;
  logic [ADDR:0] wgray_q, wgray_d;
  logic [ADDR:0] rgray_q, rgray_d;
  logic [ADDR:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  always_comb begin
    push_ack = push & ~full_q & ~reset;
    pop_ack  = pop & ~empty_q & ~reset;
    wbin_d   = wbin_q + (ADDR+1)'(push_ack);
    rbin_d   = rbin_q + (ADDR+1)'(pop_ack);
    wgray_d  = bin_gray(wbin_d);
    rgray_d  = bin_gray(rbin_d);
    empty_d  = (wgray_d == rgray_d);
    full_d   = ((wgray_d ^ rgray_d) == FULL_XOR);
    level_d  = wbin_d - rbin_d;
    ovf_d    = ovf_q | (push & full_q);
    udf_d    = udf_q | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign waddr = wbin_q[ADDR-1:0];
  assign raddr = rbin_q[ADDR-1:0];
  assign wgray = wgray_q;
  assign rgray = rgray_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl (ADDR=2): occupancy-count reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_gray_ptr_ctrl;

  localparam int ADDR = 2;
  localparam int DEPTH = 4;
  localparam int PMOD = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic            push_ack, pop_ack;
  logic [ADDR-1:0] waddr, raddr;
  logic [ADDR:0]   wgray, rgray;
  logic            full, empty;
  logic [ADDR:0]   level;
  logic            ovf, udf;

  gray_ptr_ctrl #(.ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .push_ack(push_ack), .pop_ack(pop_ack),
    .waddr(waddr), .raddr(raddr), .wgray(wgray), .rgray(rgray),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: write/read counts modulo 2*depth; Gray code from a table.
  int gray_tab [PMOD] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int m_w = 0, m_r = 0;
  bit m_ovf = 0, m_udf = 0;
  bit chk_en = 0;
  bit skip_step = 1;
  int prev_wg = 0, prev_rg = 0;

  function automatic int m_level();
    return (m_w - m_r + PMOD) % PMOD;
  endfunction

  always @(negedge clk) begin
    int lvl;
    bit exp_pa, exp_qa;
    lvl = m_level();
    exp_pa = push && (lvl != DEPTH) && !reset;
    exp_qa = pop && (lvl != 0) && !reset;
    if (chk_en) begin
      chk("push_ack", int'(push_ack), int'(exp_pa));
      chk("pop_ack", int'(pop_ack), int'(exp_qa));
      chk("level", int'(level), lvl);
      chk("full", int'(full), int'(lvl == DEPTH));
      chk("empty", int'(empty), int'(lvl == 0));
      chk("wgray", int'(wgray), gray_tab[m_w]);
      chk("rgray", int'(rgray), gray_tab[m_r]);
      chk("waddr", int'(waddr), m_w % DEPTH);
      chk("raddr", int'(raddr), m_r % DEPTH);
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("udf", int'(udf), int'(m_udf));
      if (!skip_step) begin
        chk("wgray_step", int'($countones(wgray ^ 3'(prev_wg)) <= 1), 1);
        chk("rgray_step", int'($countones(rgray ^ 3'(prev_rg)) <= 1), 1);
      end
    end
    prev_wg = int'(wgray);
    prev_rg = int'(rgray);
    skip_step = reset;
    if (reset) begin
      m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (push && lvl == DEPTH) m_ovf = 1;
      if (pop && lvl == 0) m_udf = 1;
      if (exp_pa) m_w = (m_w + 1) % PMOD;
      if (exp_qa) m_r = (m_r + 1) % PMOD;
    end
  end

  bit s_pa, s_qa;

  task automatic cyc(input bit p, input bit q, input bit r);
    push = p; pop = q; reset = r;
    @(negedge clk);
    s_pa = push_ack;
    s_qa = pop_ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int want_gray [4] = '{1, 3, 2, 6};
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk_en = 1;
    cyc(0, 0, 0);
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_full", int'(full), 0);
    chk("lit_rst_level", int'(level), 0);
    chk("lit_rst_wgray", int'(wgray), 0);
    chk("lit_rst_rgray", int'(rgray), 0);
    chk("lit_rst_flags", int'({ovf, udf}), 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk("lit_fill_ack", int'(s_pa), 1);
      chk("lit_fill_wgray", int'(wgray), want_gray[i]);
    end
    chk("lit_full", int'(full), 1);
    cyc(1, 0, 0);
    chk("lit_ovf_ack", int'(s_pa), 0);
    chk("lit_ovf", int'(ovf), 1);
    chk("lit_ovf_wgray", int'(wgray), 6);

    cyc(1, 1, 0);
    chk("lit_full_pp_push", int'(s_pa), 0);
    chk("lit_full_pp_pop", int'(s_qa), 1);
    chk("lit_full_pp_level", int'(level), 3);
    chk("lit_full_pp_full", int'(full), 0);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("lit_drained", int'(empty), 1);
    cyc(0, 1, 0);
    chk("lit_udf_ack", int'(s_qa), 0);
    chk("lit_udf", int'(udf), 1);
    cyc(1, 1, 0);
    chk("lit_empty_pp_push", int'(s_pa), 1);
    chk("lit_empty_pp_pop", int'(s_qa), 0);
    chk("lit_empty_pp_level", int'(level), 1);

    cyc(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0);
      chk("lit_steady_level", int'(level), 2);
    end

    cyc(1, 0, 0);
    chk("lit_pre_rst_level", int'(level), 3);
    cyc(1, 0, 1);
    chk("lit_rst_noack", int'(s_pa), 0);
    chk("lit_midrst_level", int'(level), 0);
    chk("lit_midrst_empty", int'(empty), 1);
    chk("lit_midrst_gray", int'({wgray, rgray}), 0);
    chk("lit_midrst_flags", int'({ovf, udf}), 0);

    for (int ph = 0; ph < 3; ph++) begin
      int pct;
      pct = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(99) < pct, $urandom_range(99) >= pct - 10,
            $urandom_range(59) == 0);
    end
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
